// File: rtl/hex_display_scan.sv
// hex_display_scan: multiplexed active-low 7-segment hex viewer.
// The value is snapshotted once per scan frame to avoid mixed digits.
module hex_display_scan #(
   parameter int bits       = 8,
   parameter int refresco   = 100000,
   parameter int num_anodos = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [bits-1:0]       valor,
   input  logic                  activar,
   output logic [num_anodos-1:0] anodos,
   output logic [7:0]            segmentos
);

   localparam int D  = (bits + 3) / 4;
   localparam int PW = 4 * D;
   localparam int CW = (refresco > 2) ? $clog2(refresco) : 1;
   localparam int IW = (D > 1) ? $clog2(D) : 1;

   localparam logic [CW-1:0] CNT_MAX = CW'(refresco - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(D - 1);

   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;
   logic [bits-1:0]       snap;
   logic                  tick;
   logic                  last;
   logic [PW-1:0]         snap_ext;
   logic [3:0]            nibble;
   logic [num_anodos-1:0] an_nxt;
   logic [7:0]            seg_nxt;

   function automatic logic [7:0] hex7(input logic [3:0] n);
      logic [7:0] s;
      unique case (n)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         4'hF: s = 8'h8E;
      endcase
      return s;
   endfunction

   assign tick     = (cnt == CNT_MAX);
   assign last     = (idx == IDX_MAX);
   assign snap_ext = PW'(snap);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // With a single digit, last is always true so idx stays 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx <= '0;
      end else if (tick) begin
         idx <= last ? '0 : idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         snap <= '0;
      end else if (tick && last) begin
         snap <= valor;
      end
   end

   // Only the D scanned digits can ever be driven low.
   always_comb begin
      nibble = 4'h0;
      an_nxt = '1;
      for (int k = 0; k < D; k++) begin
         if (idx == IW'(k)) begin
            nibble = snap_ext[4*k +: 4];
            if (activar) begin
               an_nxt[k] = 1'b0;
            end
         end
      end
      seg_nxt = activar ? hex7(nibble) : 8'hFF;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         anodos    <= '1;
         segmentos <= 8'hFF;
      end else begin
         anodos    <= an_nxt;
         segmentos <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan: directed scenarios plus random traffic,
// both checked against a time-based model of the scanned display.
module tb_hex_display_scan;

   localparam int R = 4;

   localparam logic [7:0] HEX [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       activar = 1'b1;
   logic [7:0] v8 = 8'h3A;
   logic [9:0] v10 = 10'h2F5;
   logic [7:0] an8, seg8, an10, seg10;

   int total = 0;
   int bad = 0;

   hex_display_scan #(.bits(8), .refresco(R), .num_anodos(8)) dut8 (
      .clk(clk), .rst(rst), .valor(v8), .activar(activar),
      .anodos(an8), .segmentos(seg8)
   );

   hex_display_scan #(.bits(10), .refresco(R), .num_anodos(8)) dut10 (
      .clk(clk), .rst(rst), .valor(v10), .activar(activar),
      .anodos(an10), .segmentos(seg10)
   );

   always #5 clk = ~clk;

   // Model: n counts clean edges since reset; digit = (n/R) mod D,
   // and the value is captured on the last cycle of every frame.
   int         n = 0;
   logic [7:0] s8 = '0;
   logic [9:0] s10 = '0;
   logic [7:0] m_an8 = 8'hFF, m_seg8 = 8'hFF;
   logic [7:0] m_an10 = 8'hFF, m_seg10 = 8'hFF;

   always @(posedge clk) begin
      int i8, i10;
      if (rst) begin
         n = 0;
         s8 = '0;
         s10 = '0;
         m_an8 = 8'hFF;
         m_seg8 = 8'hFF;
         m_an10 = 8'hFF;
         m_seg10 = 8'hFF;
      end else begin
         i8 = (n / R) % 2;
         i10 = (n / R) % 3;
         if (activar) begin
            m_an8 = ~(8'd1 << i8);
            m_seg8 = HEX[(int'(s8) >> (4 * i8)) & 15];
            m_an10 = ~(8'd1 << i10);
            m_seg10 = HEX[(int'(s10) >> (4 * i10)) & 15];
         end else begin
            m_an8 = 8'hFF;
            m_seg8 = 8'hFF;
            m_an10 = 8'hFF;
            m_seg10 = 8'hFF;
         end
         if (n % (2 * R) == 2 * R - 1) s8 = v8;
         if (n % (3 * R) == 3 * R - 1) s10 = v10;
         n++;
      end
   end

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      chk("an8", an8, m_an8);
      chk("seg8", seg8, m_seg8);
      chk("an10", an10, m_an10);
      chk("seg10", seg10, m_seg10);
      chk("an10_hi", {3'b000, an10[7:3]}, 8'h1F);
   endtask

   initial begin
      logic [7:0] ea, es;
      // Reset held two cycles
      repeat (2) begin
         step();
         chk("rst_an", an8, 8'hFF);
         chk("rst_seg", seg8, 8'hFF);
      end
      rst = 1'b0;

      // Scan, no-tearing and partial nibble: k = edge since release
      for (int k = 0; k < 24; k++) begin
         step();
         if (k < 8) begin
            ea = (k < 4) ? 8'hFE : 8'hFD;
            es = 8'hC0;
         end else if (k < 16) begin
            ea = (k < 12) ? 8'hFE : 8'hFD;
            es = (k < 12) ? 8'h88 : 8'hB0;
         end else begin
            ea = (k < 20) ? 8'hFE : 8'hFD;
            es = (k < 20) ? 8'hC6 : 8'h92;
         end
         chk("scan_an", an8, ea);
         chk("scan_seg", seg8, es);
         if (k >= 12) begin
            ea = (k < 16) ? 8'hFE : (k < 20) ? 8'hFD : 8'hFB;
            es = (k < 16) ? 8'h92 : (k < 20) ? 8'h8E : 8'hA4;
            chk("p10_an", an10, ea);
            chk("p10_seg", seg10, es);
         end
         if (k == 12) v8 = 8'h5C;
      end

      // Blanking during digit 0, re-enable in digit 1
      step();
      chk("blk_pre", an8, 8'hFE);
      activar = 1'b0;
      repeat (6) begin
         step();
         chk("blk_an", an8, 8'hFF);
         chk("blk_seg", seg8, 8'hFF);
      end
      activar = 1'b1;
      step();
      chk("resume_an", an8, 8'hFD);
      chk("resume_seg", seg8, 8'h92);

      // Reset in digit 1 of 3A
      v8 = 8'h3A;
      repeat (17) step();
      while (an8 !== 8'hFD || seg8 !== 8'hB0) step();
      rst = 1'b1;
      step();
      chk("mrst_an", an8, 8'hFF);
      chk("mrst_seg", seg8, 8'hFF);
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         ea = ((k % 8) < 4) ? 8'hFE : 8'hFD;
         es = (k < 8) ? 8'hC0 : 8'h88;
         chk("mrst_scan_an", an8, ea);
         chk("mrst_scan_seg", seg8, es);
      end

      // Random traffic against the model
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 9) == 0) v8 = 8'($urandom);
         if ($urandom_range(0, 9) == 0) v10 = 10'($urandom);
         if ($urandom_range(0, 15) == 0) activar = ~activar;
         rst = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
